// File: rtl/mem_bank.sv
// mem_bank: byte-masked word memory with valid/ready request and response channels and a fixed
// access latency. Define MEM_BANK_STATS_EN to enable the completed read/write counters.
module mem_bank #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_stat_reads,
    output logic [31:0] o_stat_writes
);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic          w_enter_resp;
    logic          w_leave_resp;
    logic          w_commit;

    logic          r_wen;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_mask;
    logic          r_err;

    logic          w_take_in;
    logic          w_wen;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_mask;
    logic [32:0]   w_last_byte;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    if (LATENCY == 0) begin
                        w_state_next = RESP;
                        w_enter_resp = 1'b1;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_next = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_leave_resp = (r_state == RESP) && i_rsp_ready;
    assign w_commit     = w_enter_resp && !i_rst;

    // With zero latency the access happens on the accepting edge, so use the live request.
    assign w_take_in   = (r_state == IDLE);
    assign w_wen       = w_take_in ? i_req_wen   : r_wen;
    assign w_addr      = w_take_in ? i_req_addr  : r_addr;
    assign w_wdata     = w_take_in ? i_req_wdata : r_wdata;
    assign w_mask      = w_take_in ? i_req_mask  : r_mask;
    assign w_last_byte = {1'b0, w_addr} + 33'd3;
    assign w_err       = (w_addr[1:0] != 2'b00) || (w_mask == 4'b0000) ||
                         (w_last_byte >= 33'(DEPTH_BYTES));
    assign w_idx       = w_addr[AW+1:2];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wen   <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            if (o_req_ready && i_req_valid) begin
                r_wen   <= i_req_wen;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_mask  <= i_req_mask;
            end
            if (w_enter_resp) begin
                r_err <= w_err;
            end else if (w_leave_resp) begin
                r_err <= 1'b0;
            end
        end
    end

    // One RAM per byte lane keeps the masked write a plain per-lane write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [WORDS];
        logic [7:0] r_rd;

        always_ff @(posedge i_clk) begin
            if (w_commit) begin
                if (w_wen && !w_err && w_mask[gi]) begin
                    r_mem[w_idx] <= w_wdata[8*gi +: 8];
                end
                r_rd <= r_mem[w_idx];
            end
        end

        assign w_rd_word[8*gi +: 8] = r_rd & {8{r_mask[gi]}};
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_rdata = ((r_state == RESP) && !r_err && !r_wen) ? w_rd_word : 32'd0;
    assign o_rsp_err   = r_err;

`ifdef MEM_BANK_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stat_reads  <= 32'd0;
            r_stat_writes <= 32'd0;
        end else if (w_leave_resp && !r_err) begin
            if (r_wen) begin
                r_stat_writes <= r_stat_writes + 32'd1;
            end else begin
                r_stat_reads <= r_stat_reads + 32'd1;
            end
        end
    end

    assign o_stat_reads  = r_stat_reads;
    assign o_stat_writes = r_stat_writes;
`else
    assign o_stat_reads  = 32'd0;
    assign o_stat_writes = 32'd0;
`endif

endmodule
